mdr_result_collector: RTL and testbench
=======================================

Name: mdr_result_collector

Overview:
- Gathering end of the MDR operand-distribution path.
- Operands fan out by 2-bit select to four unit channels (A–D). This block takes the four unit results and returns exactly one registered result to the requester.
- Per operation: latch the select on start, wait for the selected unit's valid, capture its data, then hold it under a valid/ready handshake.
- Flags timeouts and spurious completions from non-selected units.

Parameters:
- TIMEOUT_CYC, 64 (default from mdr_pkg::MDR_TIMEOUT_DFLT): max WAIT cycles before forced timeout completion; legal range 2..65535.
- CNT_W, $clog2(TIMEOUT_CYC+1): timeout counter width, derived; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to begin collection; accepted only in IDLE
- sel  in  2  channel select: 0=A, 1=B, 2=C, 3=D; sampled with start
- a_valid  in  1  channel A result valid
- a_data  in  DW_DBL+1  channel A result (DW_DBL from mdr_pkg)
- b_valid, b_data  in  1 / DW_DBL+1  channel B
- c_valid, c_data  in  1 / DW_DBL+1  channel C
- d_valid, d_data  in  1 / DW_DBL+1  channel D
- busy  out  1  high in WAIT and HOLD
- result  out  DW_DBL+1  captured result, registered
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- err  out  1  sticky error flag
- err_code  out  2  00 none, 01 timeout, 10 spurious, 11 timeout+spurious

Behaviour:
- Reset, asynchronous, any state: state=IDLE, result=0, result_valid=0, busy=0, err=0, err_code=00, timer=0, sel_q=0. Any operation in progress is abandoned; no partial output.
- FSM states: IDLE, WAIT, HOLD (mdr_pkg::coll_state_t). All outputs are registered.
- IDLE:
  - start=1: sel_q<=sel, timer<=0, err<=0, err_code<=00, next state WAIT.
  - busy=1 from the next cycle.
- WAIT, selected channel valid (sel_q's valid=1):
  - result<=that channel's data, result_valid<=1, next state HOLD.
  - Latency: valid at edge N gives result_valid=1 after edge N+1.
- WAIT, no selected valid:
  - timer increments each cycle.
  - When timer==TIMEOUT_CYC-1: result<=0, result_valid<=1, err<=1, err_code[0]<=1, next state HOLD.
  - Selected valid in that same cycle wins: normal capture, no timeout flag.
- WAIT, non-selected valid=1 in any cycle: err<=1, err_code[1]<=1. Sticky; collection is not aborted. If it coincides with selected valid, capture proceeds and spurious is flagged too.
- HOLD:
  - result and result_valid stable until result_ready=1.
  - On result_valid & result_ready: result_valid<=0, next state IDLE.
  - result keeps its last value after the handshake.
  - Channel valids are ignored; no spurious detection in HOLD.
- start outside IDLE is ignored, including in the HOLD handshake cycle. The earliest new start is accepted the cycle after return to IDLE.
- sel changes outside the start cycle have no effect (sel_q is used).
- err/err_code persist through HOLD and IDLE until the next accepted start.
- Width: no arithmetic on data; data passes bit-exact DW_DBL+1 bits. Timer saturates at TIMEOUT_CYC-1 and never wraps.

Decomposition:
- mdr_pkg additions:
  - coll_state_t enum {IDLE, WAIT, HOLD}
  - err_code_t as 2-bit logic with constants ERR_NONE, ERR_TMO, ERR_SPUR
  - MDR_TIMEOUT_DFLT=64
  - DW_DBL is reused, not redefined.
- One sub-module: mdr_timeout_ctr.
  - Inputs: clear, enable. Output: expired.
  - Parameter TIMEOUT_CYC. Same clk/rst scheme.
- The channel-select mux is inline combinational logic feeding the result register.

Test Plan:
- Reset, then start=1 sel=2; c_valid=1 with c_data=0x1A5 three cycles later → result_valid=1 next cycle, result=0x1A5, err=0, busy=1 until handshake.
- Hold result_ready=0 for 5 cycles in HOLD → result/result_valid stable all 5 cycles. Then result_ready=1 → result_valid=0 and busy=0 next cycle, state IDLE.
- TIMEOUT_CYC=8, start sel=0, no a_valid → after 8 WAIT cycles result_valid=1, result=0, err=1, err_code=01. Variant: a_valid=1 on the 8th cycle → normal capture, err=0.
- start sel=1 with a_valid=1 pulsed in WAIT, then b_valid data=0x3FF → result=0x3FF, err=1, err_code=10. Next accepted start clears err.
- start=1 in WAIT with sel=3, then b_valid → capture from B (second start ignored). Assert rst mid-WAIT → all outputs 0 immediately, state IDLE.
- Back-to-back: handshake cycle with start=1 → start ignored; start the following cycle → accepted, busy=1 next cycle.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared types and constants for the MDR operand-distribution path.
package mdr_pkg;

  // Double-width datapath: results carry DW_DBL+1 bits.
  localparam int unsigned DW_DBL           = 16;
  localparam int unsigned MDR_TIMEOUT_DFLT = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } coll_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE = 2'b00;
  localparam err_code_t ERR_TMO  = 2'b01;
  localparam err_code_t ERR_SPUR = 2'b10;

endpackage

// File: rtl/mdr_timeout_ctr.sv
// Saturating wait-cycle counter; expired marks the last allowed WAIT cycle.
module mdr_timeout_ctr
  import mdr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = MDR_TIMEOUT_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles, holding at LAST so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mdr_result_collector.sv
// Collects one result from the selected unit channel and returns it to the
// requester under a valid/ready handshake, flagging timeouts and spurious
// completions from non-selected channels.
module mdr_result_collector
  import mdr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = MDR_TIMEOUT_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      sel,
  input  logic            a_valid,
  input  logic [DW_DBL:0] a_data,
  input  logic            b_valid,
  input  logic [DW_DBL:0] b_data,
  input  logic            c_valid,
  input  logic [DW_DBL:0] c_data,
  input  logic            d_valid,
  input  logic [DW_DBL:0] d_data,
  output logic            busy,
  output logic [DW_DBL:0] result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            err,
  output err_code_t       err_code
);

  coll_state_t     state, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [DW_DBL:0] result_d;
  logic            result_valid_d;
  logic            err_d;
  err_code_t       err_code_d;

  logic            sel_vld;
  logic [DW_DBL:0] sel_dat;
  logic            spur;
  logic            expired;

  mdr_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (state == WAIT),
    .expired(expired)
  );

  // Channel-select mux and detection of valids on the other three channels.
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    case (sel_q)
      2'd0: begin sel_vld = a_valid; sel_dat = a_data; end
      2'd1: begin sel_vld = b_valid; sel_dat = b_data; end
      2'd2: begin sel_vld = c_valid; sel_dat = c_data; end
      default: begin sel_vld = d_valid; sel_dat = d_data; end
    endcase
    spur = |({d_valid, c_valid, b_valid, a_valid} & ~(4'b0001 << sel_q));
  end

  // Next-state and next-output decode; selected valid beats a same-cycle timeout.
  always_comb begin
    state_d        = state;
    sel_d          = sel_q;
    result_d       = result;
    result_valid_d = result_valid;
    err_d          = err;
    err_code_d     = err_code;
    case (state)
      IDLE: begin
        if (start) begin
          sel_d      = sel;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (spur) begin
          err_d      = 1'b1;
          err_code_d = err_code_d | ERR_SPUR;
        end
        if (sel_vld) begin
          result_d       = sel_dat;
          result_valid_d = 1'b1;
          state_d        = HOLD;
        end else if (expired) begin
          result_d       = '0;
          result_valid_d = 1'b1;
          err_d          = 1'b1;
          err_code_d     = err_code_d | ERR_TMO;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel_q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      state        <= state_d;
      sel_q        <= sel_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      busy         <= (state_d != IDLE);
      err          <= err_d;
      err_code     <= err_code_d;
    end
  end

endmodule

// File: tb/tb_mdr_result_collector.sv
// Scoreboard bench for mdr_result_collector with a short timeout.
module tb_mdr_result_collector;
  import mdr_pkg::*;

  localparam int unsigned TMO = 8;
  localparam int unsigned DW  = DW_DBL + 1;

  logic          clk, rst, start, result_ready;
  logic [1:0]    sel;
  logic          a_valid, b_valid, c_valid, d_valid;
  logic [DW-1:0] a_data, b_data, c_data, d_data;
  logic          busy, result_valid, err;
  logic [DW-1:0] result;
  logic [1:0]    err_code;

  mdr_result_collector #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .c_valid(c_valid), .c_data(c_data), .d_valid(d_valid), .d_data(d_data),
    .busy(busy), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] res;
    logic [1:0]    code;
  } exp_t;
  exp_t sb[$];

  // Per-WAIT-cycle channel activity for the next transaction.
  logic [3:0]    plan_v[TMO];
  logic [DW-1:0] plan_d[TMO][4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_plan();
    for (int j = 0; j < TMO; j++) begin
      plan_v[j] = 4'b0000;
      for (int c = 0; c < 4; c++) plan_d[j][c] = DW'($urandom);
    end
  endtask

  task automatic drive_ch(input int j);
    a_valid = plan_v[j][0]; a_data = plan_d[j][0];
    b_valid = plan_v[j][1]; b_data = plan_d[j][1];
    c_valid = plan_v[j][2]; c_data = plan_d[j][2];
    d_valid = plan_v[j][3]; d_data = plan_d[j][3];
  endtask

  task automatic idle_ch();
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
    a_data = DW'($urandom); b_data = DW'($urandom);
    c_data = DW'($urandom); d_data = DW'($urandom);
  endtask

  // Reference: the first cycle with the selected valid wins, otherwise the
  // transaction times out on cycle TMO-1; any other valid up to and including
  // the final WAIT cycle marks a spurious completion.
  task automatic run_txn(input logic [1:0] s, input bit stray_start, input bit hs_start,
                         input int hold_min);
    int   end_i;
    bit   found;
    bit   spur_seen;
    bit   done;
    exp_t e;
    end_i = TMO - 1;
    found = 0;
    spur_seen = 0;
    for (int j = 0; j < TMO; j++) begin
      if (!found && plan_v[j][s]) begin
        found = 1;
        end_i = j;
      end
    end
    for (int j = 0; j <= end_i; j++) begin
      for (int c = 0; c < 4; c++) begin
        if (c != int'(s) && plan_v[j][c]) spur_seen = 1;
      end
    end
    e.res  = found ? plan_d[end_i][s] : '0;
    e.code = {spur_seen, !found};
    sb.push_back(e);

    start = 1'b1;
    sel   = s;
    @(posedge clk); #1;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
    check("code_cleared_on_start", err_code, 0);
    start = 1'b0;
    for (int j = 0; j <= end_i; j++) begin
      drive_ch(j);
      if (stray_start) begin
        start = 1'b1;
        sel   = 2'd3;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    idle_ch();
    check("result_valid_latency", result_valid, 1);
    check("busy_in_hold", busy, 1);

    done = 0;
    for (int k = 0; k < 40; k++) begin
      result_ready = (k >= hold_min) && (($urandom_range(0, 1) == 1) || (k >= hold_min + 4));
      if (result_ready && hs_start) begin
        start = 1'b1;
        sel   = 2'($urandom);
      end
      @(posedge clk); #1;
      if (result_ready) begin
        done = 1;
        break;
      end
    end
    result_ready = 1'b0;
    start = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got no handshake expected handshake within 40 cycles");
    end
    check("valid_drop_after_hs", result_valid, 0);
    check("busy_drop_after_hs", busy, 0);
  endtask

  // Monitor: every cycle the result is presented it must match the oldest
  // expected entry; the entry retires on the handshake.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got result 0x%0h expected no result", result);
      end else begin
        check("result_data", result, sb[0].res);
        check("result_err_code", err_code, sb[0].code);
        check("result_err", err, {31'b0, |sb[0].code});
        if (result_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sel = 2'd0; result_ready = 1'b0;
    idle_ch();
    #12;
    check("reset_result", result, 0);
    check("reset_valid", result_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_code", err_code, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Channel C completes on the third WAIT cycle; consumer stalls 5 cycles.
    clear_plan();
    plan_v[2] = 4'b0100;
    plan_d[2][2] = DW'(17'h1A5);
    run_txn(2'd2, 0, 0, 5);

    // Full timeout on channel A.
    clear_plan();
    run_txn(2'd0, 0, 0, 0);

    // Selected valid on the final WAIT cycle beats the timeout.
    clear_plan();
    plan_v[TMO-1] = 4'b0001;
    run_txn(2'd0, 0, 0, 1);

    // Spurious A completion while waiting for B, then B delivers 0x3FF.
    clear_plan();
    plan_v[1] = 4'b0001;
    plan_v[4] = 4'b0010;
    plan_d[4][1] = DW'(17'h3FF);
    run_txn(2'd1, 0, 1, 2);

    // Back-to-back start after the handshake; stray starts with sel=3 in WAIT.
    clear_plan();
    plan_v[3] = 4'b0010;
    run_txn(2'd1, 1, 0, 0);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      logic [1:0] s;
      s = 2'($urandom);
      clear_plan();
      for (int j = 0; j < TMO; j++) begin
        for (int c = 0; c < 4; c++) begin
          if (c == int'(s)) plan_v[j][c] = ($urandom_range(0, 5) == 0);
          else              plan_v[j][c] = ($urandom_range(0, 19) == 0);
        end
      end
      run_txn(s, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of WAIT after a spurious completion.
    start = 1'b1; sel = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("spur_flag_before_reset", err_code, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("midwait_reset_busy", busy, 0);
    check("midwait_reset_valid", result_valid, 0);
    check("midwait_reset_result", result, 0);
    check("midwait_reset_err", err, 0);
    check("midwait_reset_code", err_code, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Normal operation after reset.
    clear_plan();
    plan_v[0] = 4'b1000;
    run_txn(2'd3, 0, 0, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
